bus_sequencer: RTL and testbench

Initiator side of the shared tristate register bus. Accepts one transfer request at a time (source register or immediate -> destination register) over a valid/ready handshake. Sequences the one-hot register_out / register_in strobes consumed by the bus registers, and drives the bus itself for immediates. Inserts a turnaround cycle so that no two drivers ever overlap on the bus.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/onehot_decoder.sv | 27 ++
 rtl/bus_sequencer.sv | 136 +++++++++++++
 tb/tb_bus_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
//   Shared definitions for the register-bus initiator.
//   - state_t : sequencer FSM states (IDLE=0, DRIVE=1, LATCH=2, TURN=3)
//   - id_width: smallest register-index width able to address num_regs
// ---------------------------------------------------------------------------
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      LATCH = 2'd2,
      TURN  = 2'd3
   } state_t;

   // A single register still needs a one-bit index.
   function automatic int id_width(input int num_regs);
      return (num_regs <= 2) ? 1 : $clog2(num_regs);
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// ---------------------------------------------------------------------------
// onehot_decoder
//   Turns a register index into a one-hot strobe vector, gated by en.
//   Ports:
//     idx    in  ID_W      register index
//     en     in  1         strobe enable; all zeros when low
//     onehot out NUM_REGS  one-hot strobe (at most one bit set)
// ---------------------------------------------------------------------------
module onehot_decoder #(
   parameter int NUM_REGS = 8,
   parameter int ID_W     = 3
) (
   input  logic [ID_W-1:0]     idx,
   input  logic                en,
   output logic [NUM_REGS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en && (int'(idx) == i)) begin
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_sequencer.sv
// ---------------------------------------------------------------------------
// bus_sequencer
//   Initiator of the shared tristate register bus. Takes one transfer request
//   at a time (source register or immediate -> destination register) and
//   sequences the register_out / register_in strobes, driving the bus itself
//   for immediates. A turnaround cycle after every transfer keeps two drivers
//   from ever overlapping on the bus.
//
//   Handshake: a request transfers on a posedge where req_valid && req_ready.
//   req_ready is high only in IDLE and depends on state alone; the request
//   fields are sampled only on that edge, so they may change freely at any
//   other time.
//
//   Ports:
//     clk          in     1         system clock
//     rst          in     1         synchronous reset, active low
//     req_valid    in     1         transfer request present
//     req_ready    out    1         sequencer can accept a request (IDLE)
//     req_src      in     ID_W      source register index
//     req_dst      in     ID_W      destination register index
//     req_imm_sel  in     1         1: source is req_imm
//     req_imm      in     N         immediate value
//     data         inout  N         shared bus
//     register_out out    NUM_REGS  one-hot drive enables
//     register_in  out    NUM_REGS  one-hot load enables
//     done         out    1         one-cycle pulse: transfer completed
//     done_data    out    N         bus value captured during LATCH
//     err          out    1         one-cycle pulse: request rejected
//     dbg_state    out    2         current FSM state
// ---------------------------------------------------------------------------
module bus_sequencer
   import bus_pkg::*;
#(
   parameter int N        = 16,
   parameter int NUM_REGS = 8,
   parameter int ID_W     = id_width(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ID_W-1:0]     req_src,
   input  logic [ID_W-1:0]     req_dst,
   input  logic                req_imm_sel,
   input  logic [N-1:0]        req_imm,
   inout  wire  logic [N-1:0]  data,
   output logic [NUM_REGS-1:0] register_out,
   output logic [NUM_REGS-1:0] register_in,
   output logic                done,
   output logic [N-1:0]        done_data,
   output logic                err,
   output logic [1:0]          dbg_state
);

   state_t            state;
   state_t            state_nxt;
   logic [ID_W-1:0]   src_q;
   logic [ID_W-1:0]   dst_q;
   logic              imm_sel_q;
   logic [N-1:0]      imm_q;
   logic              handshake;
   logic              reject;
   logic              drive_phase;

   // A source index is irrelevant for immediates, so only the destination is
   // range-checked in that case.
   always_comb begin
      reject = (int'(req_dst) >= NUM_REGS) ||
               (!req_imm_sel && ((int'(req_src) >= NUM_REGS) || (req_src == req_dst)));
   end

   assign req_ready   = (state == IDLE);
   assign handshake   = req_valid && req_ready;
   assign drive_phase = (state == DRIVE) || (state == LATCH);
   assign done        = (state == TURN);
   assign dbg_state   = state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         imm_sel_q <= 1'b0;
         imm_q     <= '0;
         err       <= 1'b0;
         done_data <= '0;
      end else begin
         state <= state_nxt;
         err   <= handshake && reject;
         if (handshake && !reject) begin
            src_q     <= req_src;
            dst_q     <= req_dst;
            imm_sel_q <= req_imm_sel;
            imm_q     <= req_imm;
         end
         // Same edge at which the destination register loads the bus.
         if (state == LATCH) begin
            done_data <= data;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (handshake && !reject) state_nxt = DRIVE;
         DRIVE:   state_nxt = LATCH;
         LATCH:   state_nxt = TURN;
         TURN:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The sequencer owns the bus only for immediates; register sources drive
   // it themselves through register_out, so the two never coincide.
   assign data = (drive_phase && imm_sel_q) ? imm_q : 'z;

   onehot_decoder #(
      .NUM_REGS (NUM_REGS),
      .ID_W     (ID_W)
   ) u_out_dec (
      .idx    (src_q),
      .en     (drive_phase && !imm_sel_q),
      .onehot (register_out)
   );

   onehot_decoder #(
      .NUM_REGS (NUM_REGS),
      .ID_W     (ID_W)
   ) u_in_dec (
      .idx    (dst_q),
      .en     (state == LATCH),
      .onehot (register_in)
   );

endmodule

// File: tb/tb_bus_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bus_sequencer
//   Bench for bus_sequencer with a bank of bus registers attached to data.
//   A bench-side keeper drives the bus to zero whenever nobody is expected
//   to drive it, so a stray driver shows up as a wrong value on data.
// ---------------------------------------------------------------------------
module tb_bus_sequencer;

  localparam int N        = 16;
  localparam int NUM_REGS = 8;
  localparam int ID_W     = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [ID_W-1:0]     req_src;
  logic [ID_W-1:0]     req_dst;
  logic                req_imm_sel;
  logic [N-1:0]        req_imm;
  wire  [N-1:0]        data;
  logic [NUM_REGS-1:0] register_out;
  logic [NUM_REGS-1:0] register_in;
  logic                done;
  logic [N-1:0]        done_data;
  logic                err;
  logic [1:0]          dbg_state;

  bus_sequencer #(
    .N        (N),
    .NUM_REGS (NUM_REGS),
    .ID_W     (ID_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_src      (req_src),
    .req_dst      (req_dst),
    .req_imm_sel  (req_imm_sel),
    .req_imm      (req_imm),
    .data         (data),
    .register_out (register_out),
    .register_in  (register_in),
    .done         (done),
    .done_data    (done_data),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // bus registers and keeper
  logic [N-1:0] bank [NUM_REGS];
  logic         exp_busy;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (register_in[i]) bank[i] <= data;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bank
    assign data = register_out[g] ? bank[g] : 'z;
  end

  assign data = exp_busy ? 'z : '0;

  int cyc = 0;
  always_ff @(posedge clk) cyc <= cyc + 1;

  // scoreboard / reference model
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] mem [NUM_REGS];
  logic [N-1:0] exp_q [$];
  int           hs_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_out"}, 32'(register_out), 32'd0);
    check({tag, "_in"}, 32'(register_in), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
  endtask

  // Request fields are don't-care while the sequencer is busy.
  task automatic scramble();
    logic [31:0] r;
    r = $urandom;
    req_src     = r[ID_W-1:0];
    req_dst     = r[2*ID_W-1:ID_W];
    req_imm_sel = r[31];
    req_imm     = r[30:15];
  endtask

  // driver: starts and ends at a negedge with the sequencer in IDLE
  // (illegal requests end on the err cycle, which is also IDLE).
  task automatic xfer(input int src, input int dst, input bit imm_sel, input logic [N-1:0] imm);
    bit                  legal;
    logic [N-1:0]        val;
    logic [NUM_REGS-1:0] oh_src;
    logic [NUM_REGS-1:0] oh_dst;
    logic [31:0]         s;
    logic [31:0]         d;
    legal  = (dst < NUM_REGS) && (imm_sel || ((src < NUM_REGS) && (src != dst)));
    oh_src = '0;
    oh_dst = '0;
    val    = imm;
    if (legal) begin
      oh_dst[dst] = 1'b1;
      if (!imm_sel) begin
        oh_src[src] = 1'b1;
        val = mem[src];
      end
    end
    s = src;
    d = dst;
    req_src     = s[ID_W-1:0];
    req_dst     = d[ID_W-1:0];
    req_imm_sel = imm_sel;
    req_imm     = imm;
    req_valid   = 1'b1;
    check("hs_ready", 32'(req_ready), 32'd1);
    hs_q.push_back(cyc);
    @(posedge clk);
    if (!legal) begin
      @(negedge clk);
      check("rej_err", 32'(err), 32'd1);
      check("rej_ready", 32'(req_ready), 32'd1);
      check("rej_out", 32'(register_out), 32'd0);
      check("rej_in", 32'(register_in), 32'd0);
      check("rej_done", 32'(done), 32'd0);
      check("rej_data", 32'(data), 32'd0);
      return;
    end
    exp_busy = 1'b1;
    @(negedge clk);
    scramble();
    check("drv_state", 32'(dbg_state), 32'd1);
    check("drv_out", 32'(register_out), 32'(oh_src));
    check("drv_in", 32'(register_in), 32'd0);
    check("drv_ready", 32'(req_ready), 32'd0);
    check("drv_done", 32'(done), 32'd0);
    check("drv_data", 32'(data), 32'(val));
    @(negedge clk);
    scramble();
    check("lat_state", 32'(dbg_state), 32'd2);
    check("lat_out", 32'(register_out), 32'(oh_src));
    check("lat_in", 32'(register_in), 32'(oh_dst));
    check("lat_ready", 32'(req_ready), 32'd0);
    check("lat_data", 32'(data), 32'(val));
    @(posedge clk);
    #1 exp_busy = 1'b0;
    mem[dst] = val;
    exp_q.push_back(val);
    @(negedge clk);
    check("turn_state", 32'(dbg_state), 32'd3);
    check("turn_out", 32'(register_out), 32'd0);
    check("turn_in", 32'(register_in), 32'd0);
    check("turn_done", 32'(done), 32'd1);
    check("turn_err", 32'(err), 32'd0);
    check("turn_ready", 32'(req_ready), 32'd0);
    check("turn_data", 32'(data), 32'd0);
    check("turn_done_data", 32'(done_data), 32'(exp_q.pop_front()));
    check("turn_dst_reg", 32'(bank[dst]), 32'(val));
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check_quiet("idle");
    end
  endtask

  function automatic logic [N-1:0] rand_imm();
    return N'($urandom_range(1, 65535));
  endfunction

  // strobe invariants, checked every cycle out of reset
  always @(negedge clk) begin
    if (rst) begin
      check("inv_out_onehot", 32'($countones(register_out) <= 1), 32'd1);
      check("inv_in_onehot", 32'($countones(register_in) <= 1), 32'd1);
      check("inv_done_err", 32'(done && err), 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    req_valid   = 1'b0;
    req_src     = '0;
    req_dst     = '0;
    req_imm_sel = 1'b0;
    req_imm     = '0;
    exp_busy    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", 32'(register_out), 32'd0);
    check("rst_in", 32'(register_in), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_done_data", 32'(done_data), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // preload every register through immediate transfers
    for (int r = 0; r < NUM_REGS; r++) xfer(0, r, 1'b1, rand_imm());
    idle_cycles(2);

    // register to register
    xfer(0, 2, 1'b1, 16'h1234);
    xfer(2, 5, 1'b0, rand_imm());
    check("r2r_reg5", 32'(bank[5]), 32'h1234);
    check("r2r_done_data", 32'(done_data), 32'h1234);
    idle_cycles(1);

    // immediate, with a src field equal to dst
    xfer(0, 0, 1'b1, 16'hBEEF);
    check("imm_reg0", 32'(bank[0]), 32'hBEEF);
    idle_cycles(1);

    // illegal requests
    xfer(3, 3, 1'b0, rand_imm());
    xfer(0, 8, 1'b1, rand_imm());
    xfer(9, 1, 1'b0, rand_imm());
    idle_cycles(2);

    // back-to-back with valid held high
    hs_q.delete();
    xfer(1, 6, 1'b0, rand_imm());
    xfer(7, 3, 1'b1, rand_imm());
    xfer(6, 4, 1'b0, rand_imm());
    check("b2b_gap0", 32'(hs_q[1] - hs_q[0]), 32'd4);
    check("b2b_gap1", 32'(hs_q[2] - hs_q[1]), 32'd4);
    idle_cycles(1);

    // reset in the middle of LATCH
    req_src     = 4'd1;
    req_dst     = 4'd4;
    req_imm_sel = 1'b0;
    req_imm     = rand_imm();
    req_valid   = 1'b1;
    check("mid_hs_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    exp_busy = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_in_pre", 32'(register_in), 32'h10);
    rst = 1'b0;
    @(posedge clk);
    #1 exp_busy = 1'b0;
    mem[4] = mem[1];
    @(negedge clk);
    check("mid_rst_out", 32'(register_out), 32'd0);
    check("mid_rst_in", 32'(register_in), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_done_data", 32'(done_data), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_post_ready", 32'(req_ready), 32'd1);
    idle_cycles(1);

    // sweep all legal register pairs, reloading the source each time
    for (int s = 0; s < NUM_REGS; s++) begin
      for (int d = 0; d < NUM_REGS; d++) begin
        if (s != d) begin
          xfer(0, s, 1'b1, rand_imm());
          xfer(s, d, 1'b0, rand_imm());
        end
      end
    end

    // random traffic including out-of-range indices and gaps
    for (int k = 0; k < 40; k++) begin
      xfer(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
           ($urandom_range(0, 3) == 0), rand_imm());
      if ($urandom_range(0, 2) == 0) idle_cycles(1);
    end
    idle_cycles(2);

    for (int r = 0; r < NUM_REGS; r++) check("final_reg", 32'(bank[r]), 32'(mem[r]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
